// File: rtl/matrix_alu_pkg.sv
// Shared types, op codes and addressing helper for the N x N matrix ALU.
package matrix_alu_pkg;

    // Operation codes; values 6 and 7 are illegal.
    typedef logic [2:0] op_t;

    localparam op_t OP_TRANS = 3'd0;
    localparam op_t OP_ADD   = 3'd1;
    localparam op_t OP_SUB   = 3'd2;
    localparam op_t OP_MUL   = 3'd3;
    localparam op_t OP_SCALE = 3'd4;
    localparam op_t OP_TRACE = 3'd5;

    // Sequencing engine states.
    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIN
    } state_t;

    // Row-major element address.
    function automatic int unsigned idx(input int unsigned row,
                                        input int unsigned col,
                                        input int unsigned n);
        return row * n + col;
    endfunction

    function automatic logic op_legal(input op_t o);
        return o <= OP_TRACE;
    endfunction

endpackage

// File: rtl/matrix_alu_mac.sv
// W-bit multiply-accumulate used for matrix multiply and trace.
// acc_next is the value the accumulator takes on an enabled edge, so the
// caller can store a finished sum in the same cycle as its last step.
module matrix_alu_mac
    import matrix_alu_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic         clr,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] acc,
    output logic [W-1:0] acc_next
);

    // Sum of this step's product with the running total, or a fresh start on clr.
    always_comb begin
        acc_next = (clr ? '0 : acc) + a * b;
    end

    // Accumulator register; wraps modulo 2^W.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc <= '0;
        end else if (en) begin
            acc <= acc_next;
        end
    end

endmodule

// File: rtl/matrix_alu_nxn.sv
// N x N matrix ALU: element-serial load of A/B, read of C, and a single
// sequential engine for transpose, add, subtract, multiply, scale and trace.
module matrix_alu_nxn
    import matrix_alu_pkg::*;
#(
    parameter int N  = 3,
    parameter int W  = 32,
    parameter int AW = $clog2(N*N)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_en,
    input  logic          wr_sel,
    input  logic [AW-1:0] wr_addr,
    input  logic [W-1:0]  wr_data,
    input  logic [W-1:0]  scalar,
    input  logic [2:0]    op,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          err,
    input  logic [AW-1:0] rd_addr,
    output logic [W-1:0]  rd_data,
    output logic [W-1:0]  trace_out
);

    localparam int unsigned NU = N;
    localparam int unsigned NN = N * N;
    localparam int          CW = $clog2(N);
    localparam logic [CW-1:0] NM1 = CW'(N - 1);

    state_t state, state_next;

    op_t           op_q;
    logic [W-1:0]  scalar_q;
    logic [CW-1:0] i, j, k;

    logic [W-1:0] mem_a [NN];
    logic [W-1:0] mem_b [NN];
    logic [W-1:0] mem_c [NN];

    logic          accept;
    logic          last_step;
    logic          is_mul, is_trace, is_elem;
    logic [AW-1:0] addr_ij, addr_ji, addr_ik, addr_kj, addr_ii;
    logic [W-1:0]  elem;
    logic          mac_en, mac_clr;
    logic [W-1:0]  mac_a, mac_b, mac_acc, mac_next;

    // Start is taken whenever the engine is not running (IDLE or FIN).
    assign accept   = start && (state != S_RUN);
    assign is_mul   = (op_q == OP_MUL);
    assign is_trace = (op_q == OP_TRACE);
    assign is_elem  = (op_q == OP_TRANS) || (op_q == OP_ADD) ||
                      (op_q == OP_SUB)   || (op_q == OP_SCALE);

    assign addr_ij = AW'(idx(32'(i), 32'(j), NU));
    assign addr_ji = AW'(idx(32'(j), 32'(i), NU));
    assign addr_ik = AW'(idx(32'(i), 32'(k), NU));
    assign addr_kj = AW'(idx(32'(k), 32'(j), NU));
    assign addr_ii = AW'(idx(32'(i), 32'(i), NU));

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_next = op_legal(op) ? S_RUN : S_FIN;
                end
            end
            S_RUN: begin
                busy = 1'b1;
                if (last_step) begin
                    state_next = S_FIN;
                end
            end
            S_FIN: begin
                done = 1'b1;
                if (accept) begin
                    state_next = op_legal(op) ? S_RUN : S_FIN;
                end else begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Final step detection for the latched operation.
    always_comb begin
        last_step = 1'b0;
        if (is_mul) begin
            last_step = (i == NM1) && (j == NM1) && (k == NM1);
        end else if (is_trace) begin
            last_step = (i == NM1);
        end else begin
            last_step = (i == NM1) && (j == NM1);
        end
    end

    // Operation latch, error flag and step counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            op_q     <= OP_TRANS;
            scalar_q <= '0;
            err      <= 1'b0;
            i        <= '0;
            j        <= '0;
            k        <= '0;
        end else if (accept) begin
            op_q     <= op;
            scalar_q <= scalar;
            err      <= !op_legal(op);
            i        <= '0;
            j        <= '0;
            k        <= '0;
        end else if (state == S_RUN) begin
            if (is_trace) begin
                i <= i + 1'b1;
            end else if (is_mul && (k != NM1)) begin
                k <= k + 1'b1;
            end else begin
                k <= '0;
                if (j == NM1) begin
                    j <= '0;
                    i <= i + 1'b1;
                end else begin
                    j <= j + 1'b1;
                end
            end
        end
    end

    // Elementwise result for the current (i, j).
    always_comb begin
        elem = '0;
        case (op_q)
            OP_TRANS: elem = mem_a[addr_ji];
            OP_ADD:   elem = mem_a[addr_ij] + mem_b[addr_ij];
            OP_SUB:   elem = mem_a[addr_ij] - mem_b[addr_ij];
            OP_SCALE: elem = scalar_q * mem_a[addr_ij];
            default:  elem = '0;
        endcase
    end

    // MAC operand selection: A[i][k]*B[k][j] for multiply, A[i][i]*1 for trace.
    always_comb begin
        mac_en  = (state == S_RUN) && (is_mul || is_trace);
        mac_clr = is_mul ? (k == '0) : (i == '0);
        mac_a   = is_mul ? mem_a[addr_ik] : mem_a[addr_ii];
        mac_b   = is_mul ? mem_b[addr_kj] : W'(1);
    end

    matrix_alu_mac #(
        .W(W)
    ) u_mac (
        .clk      (clk),
        .reset    (reset),
        .en       (mac_en),
        .clr      (mac_clr),
        .a        (mac_a),
        .b        (mac_b),
        .acc      (mac_acc),
        .acc_next (mac_next)
    );

    // Operand register files; host writes are frozen while the engine runs.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned e = 0; e < NN; e++) begin
                mem_a[e] <= '0;
                mem_b[e] <= '0;
            end
        end else if (wr_en && (state != S_RUN) && (32'(wr_addr) < NN)) begin
            if (wr_sel) begin
                mem_b[wr_addr] <= wr_data;
            end else begin
                mem_a[wr_addr] <= wr_data;
            end
        end
    end

    // Result register file and trace result.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned e = 0; e < NN; e++) begin
                mem_c[e] <= '0;
            end
            trace_out <= '0;
        end else if (state == S_RUN) begin
            if (is_elem) begin
                mem_c[addr_ij] <= elem;
            end else if (is_mul && (k == NM1)) begin
                mem_c[addr_ij] <= mac_next;
            end else if (is_trace && last_step) begin
                trace_out <= mac_next;
            end
        end
    end

    // Registered C read port; out-of-range addresses return zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data <= '0;
        end else if (32'(rd_addr) < NN) begin
            rd_data <= mem_c[rd_addr];
        end else begin
            rd_data <= '0;
        end
    end

endmodule

// File: tb/tb_matrix_alu_nxn.sv
// Scoreboard bench for matrix_alu_nxn at N = 3, W = 32.
module tb_matrix_alu_nxn;

    localparam int N  = 3;
    localparam int W  = 32;
    localparam int AW = $clog2(N*N);

    logic          clk = 1'b0;
    logic          reset;
    logic          wr_en;
    logic          wr_sel;
    logic [AW-1:0] wr_addr;
    logic [W-1:0]  wr_data;
    logic [W-1:0]  scalar;
    logic [2:0]    op;
    logic          start;
    logic          busy;
    logic          done;
    logic          err;
    logic [AW-1:0] rd_addr;
    logic [W-1:0]  rd_data;
    logic [W-1:0]  trace_out;

    matrix_alu_nxn #(.N(N), .W(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (wr_en),
        .wr_sel    (wr_sel),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .scalar    (scalar),
        .op        (op),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .trace_out (trace_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          busy_len;
        logic        err;
        logic        chk_tr;
        logic [31:0] tr;
    } done_t;

    typedef struct {
        logic        busy;
        logic        done;
        logic        err;
        logic [31:0] tr;
    } st_t;

    typedef struct {
        int          addr;
        logic [31:0] val;
    } rd_t;

    done_t done_q[$];
    st_t   st_q[$];
    rd_t   rd_q[$];

    int   checks = 0;
    int   errors = 0;
    int   busy_cnt = 0;
    int   wait_cyc = 0;
    logic rd_chk = 1'b0;
    logic rd_chk_d = 1'b0;
    logic st_chk = 1'b0;

    typedef logic [31:0] mat_t [9];

    mat_t m_seq   = '{0, 1, 2, 3, 4, 5, 6, 7, 8};
    mat_t m_trans = '{0, 3, 6, 1, 4, 7, 2, 5, 8};
    mat_t m_add   = '{0, 2, 4, 6, 8, 10, 12, 14, 16};
    mat_t m_zero  = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
    mat_t m_mul   = '{15, 18, 21, 42, 54, 66, 69, 90, 111};
    mat_t m_scale = '{0, 5, 10, 15, 20, 25, 30, 35, 40};
    mat_t m_a2    = '{0, 2, 2, 3, 4, 8, 6, 17, 18};
    mat_t m_b2    = '{10, 11, 12, 3, 4, 5, 6, 7, 0};
    mat_t m_sub2  = '{32'hFFFFFFF6, 32'hFFFFFFF7, 32'hFFFFFFF6, 0, 0, 3, 0, 10, 18};

    always @(posedge clk) rd_chk_d <= rd_chk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: compares DUT responses against queued expectations.
    always @(negedge clk) begin
        if (reset) begin
            busy_cnt = 0;
        end else if (busy) begin
            busy_cnt++;
        end
        if (done) begin
            if (done_q.size() == 0) begin
                check("done_unexpected", 32'd1, 32'd0);
            end else begin
                done_t d;
                d = done_q.pop_front();
                check("busy_cycles", 32'(busy_cnt), 32'(d.busy_len));
                check("err_at_done", {31'd0, err}, {31'd0, d.err});
                check("busy_at_done", {31'd0, busy}, 32'd0);
                if (d.chk_tr) check("trace_out", trace_out, d.tr);
            end
            busy_cnt = 0;
            wait_cyc = 0;
        end else if (done_q.size() != 0) begin
            wait_cyc++;
            if (wait_cyc > 50) begin
                check("done_timeout", 32'd0, 32'd1);
                void'(done_q.pop_front());
                wait_cyc = 0;
            end
        end
        if (rd_chk_d) begin
            if (rd_q.size() == 0) begin
                check("read_unexpected", 32'd1, 32'd0);
            end else begin
                rd_t r;
                r = rd_q.pop_front();
                check($sformatf("rd_data[%0d]", r.addr), rd_data, r.val);
            end
        end
        if (st_chk && st_q.size() != 0) begin
            st_t s;
            s = st_q.pop_front();
            check("status_busy", {31'd0, busy}, {31'd0, s.busy});
            check("status_done", {31'd0, done}, {31'd0, s.done});
            check("status_err", {31'd0, err}, {31'd0, s.err});
            check("status_trace", trace_out, s.tr);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic sel, input mat_t m);
        for (int e = 0; e < 9; e++) begin
            wr_en   = 1'b1;
            wr_sel  = sel;
            wr_addr = AW'(e);
            wr_data = m[e];
            tick();
        end
        wr_en = 1'b0;
    endtask

    task automatic read_all(input mat_t m);
        for (int e = 0; e < 9; e++) begin
            rd_q.push_back('{e, m[e]});
            rd_addr = AW'(e);
            rd_chk  = 1'b1;
            tick();
        end
        rd_chk = 1'b0;
        tick();
    endtask

    task automatic read_one(input int a, input logic [31:0] v);
        rd_q.push_back('{a, v});
        rd_addr = AW'(a);
        rd_chk  = 1'b1;
        tick();
        rd_chk = 1'b0;
        tick();
    endtask

    task automatic probe(input logic b, input logic d, input logic e, input logic [31:0] t);
        st_q.push_back('{b, d, e, t});
        st_chk = 1'b1;
        tick();
        st_chk = 1'b0;
    endtask

    task automatic wait_done();
        for (int n = 0; n < 60; n++) begin
            if (done) break;
            tick();
        end
        tick();
    endtask

    // Issue one operation and queue what its completion must look like.
    task automatic run(input logic [2:0] o, input logic [31:0] s, input int blen,
                       input logic e, input logic ctr, input logic [31:0] t);
        done_q.push_back('{blen, e, ctr, t});
        op     = o;
        scalar = s;
        start  = 1'b1;
        tick();
        start = 1'b0;
        wait_done();
    endtask

    initial begin
        reset   = 1'b1;
        wr_en   = 1'b0;
        wr_sel  = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        scalar  = '0;
        op      = '0;
        start   = 1'b0;
        rd_addr = '0;
        tick();
        tick();
        reset = 1'b0;
        probe(1'b0, 1'b0, 1'b0, 32'd0);
        read_one(0, 32'd0);

        load(1'b0, m_seq);
        load(1'b1, m_seq);
        run(3'd0, 32'd0, 9, 1'b0, 1'b0, 32'd0);
        read_all(m_trans);
        run(3'd1, 32'd0, 9, 1'b0, 1'b0, 32'd0);
        read_all(m_add);
        run(3'd2, 32'd0, 9, 1'b0, 1'b0, 32'd0);
        read_all(m_zero);
        run(3'd3, 32'd0, 27, 1'b0, 1'b0, 32'd0);
        read_all(m_mul);
        run(3'd4, 32'd5, 9, 1'b0, 1'b0, 32'd0);
        read_all(m_scale);
        run(3'd5, 32'd0, 3, 1'b0, 1'b1, 32'd12);
        read_all(m_scale);

        // SUB with a write to A[8] attempted mid-run; it must be dropped.
        load(1'b0, m_a2);
        load(1'b1, m_b2);
        done_q.push_back('{9, 1'b0, 1'b0, 32'd0});
        op    = 3'd2;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        wr_en   = 1'b1;
        wr_sel  = 1'b0;
        wr_addr = AW'(8);
        wr_data = 32'd99;
        tick();
        wr_en = 1'b0;
        wait_done();
        read_all(m_sub2);

        // MUL aborted by reset at step 13, with a repeated start on the same edge.
        op    = 3'd3;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (13) tick();
        start = 1'b1;
        reset = 1'b1;
        tick();
        start = 1'b0;
        reset = 1'b0;
        probe(1'b0, 1'b0, 1'b0, 32'd0);
        read_all(m_zero);
        load(1'b0, m_seq);
        load(1'b1, m_seq);
        run(3'd1, 32'd0, 9, 1'b0, 1'b0, 32'd0);
        read_all(m_add);

        // Illegal op: immediate done, sticky err, C untouched.
        run(3'd6, 32'd0, 0, 1'b1, 1'b0, 32'd0);
        probe(1'b0, 1'b0, 1'b1, 32'd0);
        read_all(m_add);
        read_one(9, 32'd0);
        run(3'd5, 32'd0, 3, 1'b0, 1'b1, 32'd12);
        probe(1'b0, 1'b0, 1'b0, 32'd12);

        repeat (5) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
